// File: rtl/tnn_feature_loader.sv
// ============================================================================
//  Module   : tnn_feature_loader
//  Purpose  : Upstream stage of the 5-input 2-bit ternary classifier core.
//             Accepts raw feature bytes on a valid/ready stream, quantises
//             each to Q_W bits against three fixed thresholds and assembles
//             N_FEAT-feature frames. Each finished frame is presented as a
//             registered vector with valid/ready. An assembly register plus
//             an output register give one frame per N_FEAT beats.
//  Ports    : clk, rst_n (async, active low)
//             s_valid/s_ready/s_data/s_last : raw feature stream in
//             m_valid/m_ready/m_vec         : quantised frame out,
//                                             slot k at [k*Q_W +: Q_W]
//             err_frame                     : 1-cycle framing-error pulse
//  Option   : TNN_LOADER_STATS_EN adds frame_cnt[15:0] (wrapping count of
//             accepted output frames) and drop_cnt[7:0] (saturating count
//             of discarded short frames).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tnn_feature_loader #(
    parameter int N_FEAT = 5,
    parameter int IN_W   = 8,
    parameter int Q_W    = 2,
    parameter int THR1   = 64,
    parameter int THR2   = 128,
    parameter int THR3   = 192
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [IN_W-1:0]        s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [N_FEAT*Q_W-1:0]  m_vec,
    output logic                   err_frame
`ifdef TNN_LOADER_STATS_EN
    ,
    output logic [15:0]            frame_cnt,
    output logic [7:0]             drop_cnt
`endif
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int VEC_W = N_FEAT * Q_W;

    localparam logic [IN_W-1:0]  c_THR1     = IN_W'(THR1);
    localparam logic [IN_W-1:0]  c_THR2     = IN_W'(THR2);
    localparam logic [IN_W-1:0]  c_THR3     = IN_W'(THR3);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_FEAT - 1);

    // COLLECT: accepting beats. FULL: assembled frame waits for output reg.
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [VEC_W-1:0] asm_q,     asm_d;
    logic [VEC_W-1:0] out_q,     out_d;
    logic             m_valid_q, m_valid_d;
    logic             err_q,     err_d;

    logic [Q_W-1:0]   w_quant;
    logic [VEC_W-1:0] w_frame;
    logic             w_accept;
    logic             w_out_free;
    logic             w_short;
    logic             w_long;

    always_comb begin
        if (s_data >= c_THR3) begin
            w_quant = Q_W'(3);
        end else if (s_data >= c_THR2) begin
            w_quant = Q_W'(2);
        end else if (s_data >= c_THR1) begin
            w_quant = Q_W'(1);
        end else begin
            w_quant = Q_W'(0);
        end
    end

    // Assembly register with the current beat merged in, so a completing
    // beat can go straight to the output register without an extra cycle.
    always_comb begin
        w_frame = asm_q;
        w_frame[idx_q*Q_W +: Q_W] = w_quant;
    end

    assign s_ready    = (state_q == COLLECT);
    assign w_accept   = s_valid && s_ready;
    // Output register can take a new frame if empty or emptying this cycle.
    assign w_out_free = !m_valid_q || m_ready;
    assign w_short    = w_accept && s_last && (idx_q != c_LAST_IDX);
    assign w_long     = w_accept && !s_last && (idx_q == c_LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        out_d     = out_q;
        m_valid_d = m_valid_q && !m_ready;
        err_d     = w_short || w_long;

        if (state_q == FULL) begin
            if (w_out_free) begin
                out_d     = asm_q;
                m_valid_d = 1'b1;
                state_d   = COLLECT;
            end
        end else if (w_accept) begin
            asm_d = w_frame;
            if (idx_q == c_LAST_IDX) begin
                idx_d = '0;
                if (w_out_free) begin
                    out_d     = w_frame;
                    m_valid_d = 1'b1;
                end else begin
                    state_d = FULL;
                end
            end else if (s_last) begin
                // Short frame: stale slots are overwritten by the next frame.
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            asm_q     <= '0;
            out_q     <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_vec     = out_q;
    assign err_frame = err_q;

`ifdef TNN_LOADER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (m_valid_q && m_ready) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (w_short && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

`default_nettype wire
